// File: rtl/arith_pkg.sv
// Shared definitions for the restoring divider: default widths, counter sizing, FSM states.
package arith_pkg;

  localparam int unsigned DefNDvd = 16;
  localparam int unsigned DefNDvs = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefCntW = cnt_width(DefNDvd);

  typedef enum logic [2:0] {StIdle, StPrep, StDiv, StFix, StDone} state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on an unsigned partial remainder.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   prem,
  input  logic         din,
  input  logic [W-1:0] dvs,
  output logic [W:0]   nrem,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  always_comb begin
    shifted = {prem, din};
    diff    = shifted - {2'b00, dvs};
    // The top bit of diff is the borrow: no borrow means the divisor fits.
    qbit    = ~diff[W+1];
    nrem    = qbit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/restoring_div.sv
// Multi-cycle signed restoring divider: magnitudes are divided one bit per cycle,
// signs are re-applied at the end. Truncating semantics, remainder follows dividend.
module restoring_div
  import arith_pkg::*;
#(
  parameter int unsigned N_DVD = DefNDvd,
  parameter int unsigned N_DVS = DefNDvs
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DVD-1:0] Y,
  input  logic [N_DVS-1:0] B,
  input  logic             load,
  output logic [N_DVD-1:0] Q,
  output logic [N_DVS-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(N_DVD);

  state_e state_q, state_d;

  logic [N_DVD-1:0] y_q;
  logic [N_DVS-1:0] b_q;
  logic [N_DVD-1:0] a_q;      // dividend magnitude, becomes quotient magnitude
  logic [N_DVS-1:0] bmag_q;
  logic [N_DVS:0]   prem_q;
  logic [CntW-1:0]  cnt_q;
  logic             qsign_q;
  logic             rsign_q;
  logic [N_DVD-1:0] q_q;
  logic [N_DVS-1:0] r_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [N_DVS:0]   step_rem;
  logic             step_q;

  div_step #(
    .W(N_DVS)
  ) u_step (
    .prem(prem_q),
    .din (a_q[N_DVD-1]),
    .dvs (bmag_q),
    .nrem(step_rem),
    .qbit(step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) state_d = StPrep;
      end
      StPrep: begin
        busy = 1'b1;
        // A zero divisor bypasses the iteration loop entirely.
        state_d = (b_q == '0) ? StFix : StDiv;
      end
      StDiv: begin
        busy = 1'b1;
        if (cnt_q == CntW'(N_DVD - 1)) state_d = StFix;
      end
      StFix: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      bmag_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            y_q <= Y;
            b_q <= B;
          end
        end
        StPrep: begin
          a_q     <= y_q[N_DVD-1] ? -y_q : y_q;
          bmag_q  <= b_q[N_DVS-1] ? -b_q : b_q;
          qsign_q <= y_q[N_DVD-1] ^ b_q[N_DVS-1];
          rsign_q <= y_q[N_DVD-1];
          prem_q  <= '0;
          cnt_q   <= '0;
          if (b_q == '0) begin
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b1;
            ovf_q <= 1'b0;
          end
        end
        StDiv: begin
          prem_q <= step_rem;
          a_q    <= {a_q[N_DVD-2:0], step_q};
          cnt_q  <= cnt_q + CntW'(1);
        end
        StFix: begin
          if (b_q != '0) begin
            q_q   <= qsign_q ? -a_q : a_q;
            r_q   <= rsign_q ? -prem_q[N_DVS-1:0] : prem_q[N_DVS-1:0];
            dbz_q <= 1'b0;
            // Only most-negative / -1 yields a positive magnitude with the MSB set.
            ovf_q <= ~qsign_q & a_q[N_DVD-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign Q   = q_q;
  assign R   = r_q;
  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule

// File: doc/restoring_div.md
RESTORING_DIV -- requirements
Module: restoring_div

Interface
REQ-001 SHALL use parameter N_DVD, default 16, meaning dividend and quotient width.
REQ-002 SHALL use parameter N_DVS, default 8, meaning divisor and remainder width.
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Y  input  N_DVD  signed two's-complement dividend, sampled with load.
REQ-006 SHALL have port B  input  N_DVS  signed two's-complement divisor, sampled with load.
REQ-007 SHALL have port load  input  1  start request, honoured only in IDLE.
REQ-008 SHALL have port Q  output  N_DVD  signed quotient, registered.
REQ-009 SHALL have port R  output  N_DVS  signed remainder, registered.
REQ-010 SHALL have port busy  output  1  high from accepted load until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse when Q/R/flags become valid.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag, valid with done.
REQ-013 SHALL have port ovf  output  1  quotient-overflow flag, valid with done.

Function
REQ-014 SHALL compute truncating signed division: Q = trunc(Y/B), R = Y - Q*B; R sign follows Y, |R| < |B|.
REQ-015 SHALL implement FSM states IDLE, PREP, DIV, FIX, DONE.
REQ-016 IDLE: load=1 at edge k captures Y, B -> PREP; busy=1 after edge k.
REQ-017 PREP (edge k+1): store |Y| (N_DVD bits unsigned), |B| (N_DVS bits unsigned), result sign = Y[msb]^B[msb], remainder sign = Y[msb]; clear iteration counter -> DIV.
REQ-018 PREP with B==0 SHALL skip to DONE with Q=0, R=0, dbz=1, ovf=0.
REQ-019 DIV SHALL perform one restoring step per cycle (shift partial remainder left, bring in next dividend bit, subtract |B| if no borrow, set quotient bit), exactly N_DVD cycles (edges k+2..k+17 at defaults).
REQ-020 Partial remainder SHALL be N_DVS+1 bits wide so |B|=2^(N_DVS-1) never truncates.
REQ-021 FIX (edge k+18) SHALL apply signs, register Q and R, set dbz/ovf -> DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, deassert busy, then -> IDLE; latency load-edge to done-high = 19 cycles at defaults (3 for divide-by-zero).
REQ-023 Y = most-negative, B = -1 SHALL give ovf=1, Q = most-negative (16'h8000), R=0.
REQ-024 load asserted while busy SHALL be ignored; no effect on operation in flight.
REQ-025 load held high through DONE SHALL start a new operation only once back in IDLE.
REQ-026 Q, R, dbz, ovf SHALL hold last result until next FIX/DONE update; Y and B may change freely after the load edge.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, Q=0, R=0, busy=0, done=0, dbz=0, ovf=0, clear counter and working registers.
REQ-028 rst mid-operation SHALL abort without a done pulse; rst has priority over load in the same cycle.

Structure
REQ-029 Shared package arith_pkg SHALL hold the FSM state enum, default widths N_DVD/N_DVS, and iteration-counter width.
REQ-030 One sub-module div_step (combinational single restoring step: partial remainder, divisor in; next remainder, quotient bit out) SHALL be instantiated once in the DIV datapath.

Verification
REQ-031 rst 10 ns, load Y=600, B=30 -> done 19 cycles later, Q=20, R=0, dbz=0, ovf=0.
REQ-032 Y=1000, B=-7 -> Q=-142 (16'hFF72), R=6; Y=-1000, B=7 -> Q=-142, R=-6.
REQ-033 Y=-32768, B=-1 -> ovf=1, Q=16'h8000, R=0; Y=-32768, B=-128 -> Q=256, R=0, ovf=0.
REQ-034 Y=1234, B=0 -> done 3 cycles after load, dbz=1, Q=0, R=0.
REQ-035 load Y=600, B=30, second load Y=5, B=1 at cycle 5 -> ignored, result Q=20; rst at cycle 8 -> no done, all outputs 0, busy=0.
REQ-036 Random signed Y/B sweep (B≠0, excluding overflow case) -> Q*B+R==Y, |R|<|B|, sign(R) matches sign(Y) or R=0.
